// File: rtl/timer_bank_pkg.sv
// Shared register map and field positions for the APB3 timer bank.
package timer_bank_pkg;

  // Register offsets inside one channel window
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LOAD   = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // Channel windows are 16 bytes apart; the channel index sits right above the offset
  localparam int CH_SHIFT  = 4;
  localparam int CH_STRIDE = 1 << CH_SHIFT;

  // Summary register of all pending flags
  localparam int GLOBAL_PEND_OFF = 'h100;

  // Width of the irq pulse stretcher (PULSE is at most 255)
  localparam int PULSE_W = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with reload, pending flag and irq pulse stretcher.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PULSE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_we,
  input  logic [2:0]       ctrl_wdata,
  input  logic             load_we,
  input  logic [CNT_W-1:0] load_wdata,
  input  logic             status_clr,
  output logic [2:0]       ctrl,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic             pending,
  output logic             pulse
);

  logic                stop_wr;
  logic                start_wr;
  logic                running;
  logic                expire;
  logic                periodic_eff;
  logic [PULSE_W-1:0]  pulse_cnt;

  // A disabling write in the same cycle as count==1 suppresses the expiry.
  assign stop_wr      = ctrl_we && !ctrl_wdata[CTRL_EN];
  assign start_wr     = ctrl_we && ctrl_wdata[CTRL_EN] && !ctrl[CTRL_EN];
  assign running      = ctrl[CTRL_EN] && !stop_wr;
  assign expire       = running && (count == CNT_W'(1));
  assign periodic_eff = ctrl_we ? ctrl_wdata[CTRL_PERIODIC] : ctrl[CTRL_PERIODIC];
  assign pulse        = (pulse_cnt != '0);

  // Configuration registers; a one-shot expiry drops the enable bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      load <= '0;
    end else begin
      if (load_we) load <= load_wdata;
      if (ctrl_we) ctrl <= ctrl_wdata;
      if (expire && !periodic_eff) ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // Counter: load on enable, decrement while running, reload or park at 0 on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start_wr) begin
      count <= load;
    end else if (expire) begin
      count <= periodic_eff ? load : '0;
    end else if (running && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Pending flag: a same-cycle expiry beats the W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (expire) begin
      pending <= 1'b1;
    end else if (status_clr) begin
      pending <= 1'b0;
    end
  end

  // Pulse stretcher: each expiry restarts the full PULSE-cycle window.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_cnt <= '0;
    end else if (expire) begin
      pulse_cnt <= PULSE_W'(PULSE);
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - PULSE_W'(1);
    end
  end

endmodule

// File: rtl/apb3_timer_bank.sv
// APB3 slave exposing NCH independent down-counting timers with irq pulse and level outputs.
module apb3_timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CNT_W      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int PULSE      = 1
) (
  input  logic                  io_systemClk,
  input  logic                  io_systemReset,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERROR,
  output logic [NCH-1:0]        irq_pulse,
  output logic                  irq_level
);

  logic                      access;
  logic                      in_ch;
  logic                      is_gp;
  logic                      off_ok;
  logic                      mapped;
  logic                      err;
  logic                      wr_ok;
  logic [3:0]                ch_sel;
  logic [3:0]                off;
  logic [31:0]               rdata;

  logic [NCH-1:0][2:0]       ctrl_q;
  logic [NCH-1:0][CNT_W-1:0] load_q;
  logic [NCH-1:0][CNT_W-1:0] count_q;
  logic [NCH-1:0]            pending_q;
  logic [NCH-1:0]            irq_src;

  assign access = PSEL & PENABLE;
  assign ch_sel = PADDR[CH_SHIFT+3:CH_SHIFT];
  assign off    = PADDR[3:0];
  assign in_ch  = PADDR < ADDR_WIDTH'(NCH * CH_STRIDE);
  assign is_gp  = PADDR == ADDR_WIDTH'(GLOBAL_PEND_OFF);
  assign off_ok = (off == OFF_CTRL) || (off == OFF_LOAD) ||
                  (off == OFF_COUNT) || (off == OFF_STATUS);
  assign mapped = is_gp || (in_ch && off_ok);
  assign err    = access && (!mapped || (PWRITE && (is_gp || off == OFF_COUNT)));
  assign wr_ok  = access && PWRITE && !err && !io_systemReset;

  assign PREADY    = 1'b1;
  assign PSLVERROR = err && !io_systemReset;
  assign irq_level = |irq_src;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr      = wr_ok && in_ch && (ch_sel == 4'(c));
    assign irq_src[c] = pending_q[c] & ctrl_q[c][CTRL_IRQ_EN];

    timer_channel #(
      .CNT_W (CNT_W),
      .PULSE (PULSE)
    ) u_ch (
      .clk        (io_systemClk),
      .rst        (io_systemReset),
      .ctrl_we    (ch_wr && (off == OFF_CTRL)),
      .ctrl_wdata (PWDATA[2:0]),
      .load_we    (ch_wr && (off == OFF_LOAD)),
      .load_wdata (PWDATA[CNT_W-1:0]),
      .status_clr (ch_wr && (off == OFF_STATUS) && PWDATA[0]),
      .ctrl       (ctrl_q[c]),
      .load       (load_q[c]),
      .count      (count_q[c]),
      .pending    (pending_q[c]),
      .pulse      (irq_pulse[c])
    );
  end

  // Read mux; only reads of mapped registers outside reset reach PRDATA.
  always_comb begin
    rdata = '0;
    if (is_gp) begin
      rdata = 32'(pending_q);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_sel == 4'(c)) begin
          case (off)
            OFF_CTRL:   rdata = 32'(ctrl_q[c]);
            OFF_LOAD:   rdata = 32'(load_q[c]);
            OFF_COUNT:  rdata = 32'(count_q[c]);
            OFF_STATUS: rdata = 32'(pending_q[c]);
            default:    rdata = '0;
          endcase
        end
      end
    end
    PRDATA = (access && !PWRITE && mapped && !io_systemReset) ? rdata : '0;
  end

endmodule

// File: tb/tb_apb3_timer_bank.sv
// Scoreboard bench for apb3_timer_bank: two instances (PULSE=1, NCH=4 and PULSE=4, NCH=2) on a shared APB bus.
module tb_apb3_timer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        psel_a, psel_b, penable, pwrite;
  logic [31:0] pwdata;

  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, perr_a, perr_b;
  logic [3:0]  irq_pulse_a;
  logic [1:0]  irq_pulse_b;
  logic        irq_level_a, irq_level_b;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Edge counter used to place expectations relative to commit edges
  always @(posedge clk) cyc <= cyc + 1;

  apb3_timer_bank #(.NCH(4), .CNT_W(32), .ADDR_WIDTH(16), .PULSE(1)) dut_a (
    .io_systemClk   (clk),
    .io_systemReset (rst),
    .PADDR          (paddr),
    .PSEL           (psel_a),
    .PENABLE        (penable),
    .PWRITE         (pwrite),
    .PWDATA         (pwdata),
    .PRDATA         (prdata_a),
    .PREADY         (pready_a),
    .PSLVERROR      (perr_a),
    .irq_pulse      (irq_pulse_a),
    .irq_level      (irq_level_a)
  );

  apb3_timer_bank #(.NCH(2), .CNT_W(32), .ADDR_WIDTH(16), .PULSE(4)) dut_b (
    .io_systemClk   (clk),
    .io_systemReset (rst),
    .PADDR          (paddr),
    .PSEL           (psel_b),
    .PENABLE        (penable),
    .PWRITE         (pwrite),
    .PWDATA         (pwdata),
    .PRDATA         (prdata_b),
    .PREADY         (pready_b),
    .PSLVERROR      (perr_b),
    .irq_pulse      (irq_pulse_b),
    .irq_level      (irq_level_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Pops one expectation for every access phase seen on the bus
  task automatic monitor();
    forever begin
      @(negedge clk);
      if ((psel_a || psel_b) && penable) begin
        exp_t        e;
        logic [31:0] rd;
        logic        er, rdy;
        rd  = psel_b ? prdata_b : prdata_a;
        er  = psel_b ? perr_b   : perr_a;
        rdy = psel_b ? pready_b : pready_a;
        if (sb.size() == 0) begin
          check("sb_unexpected_access", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check({e.name, "_prdata"}, rd, e.data);
          check({e.name, "_pslverr"}, 32'(er), 32'(e.err));
          check({e.name, "_pready"}, 32'(rdy), 32'(1));
        end
      end
    end
  endtask

  task automatic apb(input bit b, input logic [15:0] a, input bit wr, input logic [31:0] wd,
                     input logic [31:0] ed, input bit ee, input string nm);
    exp_t e;
    e.name = nm;
    e.data = wr ? 32'h0 : ed;
    e.err  = ee;
    sb.push_back(e);
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    psel_a  = !b;
    psel_b  = b;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input bit b, input logic [15:0] a, input logic [31:0] d, input string nm);
    apb(b, a, 1'b1, d, 32'h0, 1'b0, nm);
  endtask

  task automatic rd(input bit b, input logic [15:0] a, input logic [31:0] exp, input string nm);
    apb(b, a, 1'b0, 32'h0, exp, 1'b0, nm);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_hi(input bit b, input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (b ? irq_pulse_b[ch] : irq_pulse_a[ch]) hi++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int en0, d, hi, lv;
    rst = 1'b1; paddr = '0; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0; pwdata = '0;

    fork
      monitor();
    join_none
    fork
      begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_irq_pulse_a", 32'(irq_pulse_a), 32'(0));
    check("rst_irq_level_a", 32'(irq_level_a), 32'(0));
    rd(0, 16'h0000, 32'h0, "rst_ctrl0");
    rd(0, 16'h0004, 32'h0, "rst_load0");
    rd(0, 16'h0008, 32'h0, "rst_count0");
    rd(0, 16'h000C, 32'h0, "rst_status0");
    rd(0, 16'h0100, 32'h0, "rst_gp");

    // Periodic ch0, LOAD=5: count sequence and pulse spacing
    wr(0, 16'h0004, 32'd5, "ld0");
    wr(0, 16'h0000, 32'h3, "ctrl0");
    en0 = cyc;
    for (int k = 0; k < 5; k++) rd(0, 16'h0008, 32'(5 - ((cyc + 1 - en0) % 5)), "count0");
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("pulse0", 32'(irq_pulse_a[0]), 32'(((cyc - en0) > 0) && ((cyc - en0) % 5 == 0)));
    end
    @(posedge clk); #1;
    wr(0, 16'h0000, 32'h2, "stop0");
    d = cyc;
    rd(0, 16'h0008, 32'(5 - ((d - 1 - en0) % 5)), "count0_frozen");
    rd(0, 16'h0000, 32'h2, "ctrl0_after_stop");

    // Error accesses
    apb(0, 16'h0008, 1'b1, 32'h55, 32'h0, 1'b1, "wr_count");
    rd(0, 16'h0008, 32'(5 - ((d - 1 - en0) % 5)), "count0_after_bad_wr");
    apb(0, 16'h0200, 1'b0, 32'h0, 32'h0, 1'b1, "rd_200");
    apb(0, 16'h0050, 1'b0, 32'h0, 32'h0, 1'b1, "rd_ch5");
    apb(0, 16'h0054, 1'b1, 32'h7, 32'h0, 1'b1, "wr_ch5");
    apb(0, 16'h0040, 1'b0, 32'h0, 32'h0, 1'b1, "rd_ch4");
    apb(0, 16'h0100, 1'b1, 32'hF, 32'h0, 1'b1, "wr_gp");
    apb(0, 16'h0002, 1'b0, 32'h0, 32'h0, 1'b1, "rd_unaligned");
    apb(1, 16'h0020, 1'b0, 32'h0, 32'h0, 1'b1, "b_rd_ch2");

    // One-shot ch1, LOAD=3, irq enabled
    wr(0, 16'h0014, 32'd3, "ld1");
    wr(0, 16'h0010, 32'h5, "ctrl1");
    count_hi(0, 1, 8, hi);
    check("oneshot_pulses", 32'(hi), 32'(1));
    rd(0, 16'h0010, 32'h4, "ctrl1_after");
    rd(0, 16'h0018, 32'h0, "count1_after");
    rd(0, 16'h001C, 32'h1, "status1_set");
    check("irq_level_set", 32'(irq_level_a), 32'(1));
    rd(0, 16'h0100, 32'h3, "gp_both");
    wr(0, 16'h001C, 32'h1, "w1c1");
    check("irq_level_clr", 32'(irq_level_a), 32'(0));
    rd(0, 16'h001C, 32'h0, "status1_clr");
    rd(0, 16'h0100, 32'h1, "gp_ch0");

    // ch2 LOAD=4: W1C on an expiry edge, then a disable on an expiry edge
    wr(0, 16'h0024, 32'd4, "ld2");
    wr(0, 16'h0020, 32'h3, "ctrl2");
    wait_cycles(6);
    wr(0, 16'h002C, 32'h1, "w1c_on_expiry");
    rd(0, 16'h002C, 32'h1, "status2_set_wins");
    wr(0, 16'h0020, 32'h0, "stop2_on_expiry");
    @(negedge clk);
    check("stop_wins_pulse", 32'(irq_pulse_a[2]), 32'(0));
    @(posedge clk); #1;
    rd(0, 16'h0028, 32'h1, "count2_frozen");
    wr(0, 16'h002C, 32'h1, "w1c2");
    rd(0, 16'h002C, 32'h0, "status2_clr");

    // Instance B (PULSE=4): LOAD=2 periodic keeps irq_pulse high
    wr(1, 16'h0004, 32'd2, "b_ld0");
    wr(1, 16'h0000, 32'h3, "b_ctrl0");
    wait_cycles(2);
    count_hi(1, 0, 16, hi);
    check("retrigger_high", 32'(hi), 32'(16));
    wr(1, 16'h0000, 32'h0, "b_stop0");
    @(negedge clk);
    check("pulse_completes", 32'(irq_pulse_b[0]), 32'(1));
    @(posedge clk); #1;
    wait_cycles(4);
    @(negedge clk);
    check("pulse_ends", 32'(irq_pulse_b[0]), 32'(0));
    @(posedge clk); #1;

    // LOAD=0 with enable: never expires
    wr(1, 16'h0010, 32'h3, "b_ctrl1_load0");
    count_hi(1, 1, 12, hi);
    check("load0_no_pulse", 32'(hi), 32'(0));
    rd(1, 16'h0018, 32'h0, "b_count1");
    rd(1, 16'h001C, 32'h0, "b_status1");
    rd(1, 16'h0100, 32'h1, "b_gp");

    // Reset two cycles before expiry of LOAD=10
    wr(0, 16'h0034, 32'd10, "ld3");
    wr(0, 16'h0030, 32'h7, "ctrl3");
    wait_cycles(7);
    rst = 1'b1;
    hi = 0;
    lv = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (irq_pulse_a[3]) hi++;
      if (irq_level_a) lv++;
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
    end
    check("rst_no_pulse", 32'(hi), 32'(0));
    check("rst_no_level", 32'(lv), 32'(0));
    rd(0, 16'h0030, 32'h0, "post_rst_ctrl3");
    rd(0, 16'h0034, 32'h0, "post_rst_load3");
    rd(0, 16'h0038, 32'h0, "post_rst_count3");
    rd(0, 16'h003C, 32'h0, "post_rst_status3");
    rd(0, 16'h0004, 32'h0, "post_rst_load0");
    rd(0, 16'h0100, 32'h0, "post_rst_gp");
    rd(1, 16'h0100, 32'h0, "post_rst_b_gp");

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
